// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared systolic-array widths and writer state encoding
package sa_pkg;

    localparam int ADDR_W     = 6;
    localparam int DATA_W     = 8;
    localparam int TILE_ELEMS = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } wr_state_t;

endpackage

// File: rtl/sa_result_writer_if.sv
// rtl/sa_result_writer_if.sv - job control, SA tile input and RAM write port of the result writer
interface sa_result_writer_if;
    import sa_pkg::*;

    logic              start_i;
    logic [ADDR_W-1:0] result_baseaddr;
    logic              result_valid_i;
    logic [DATA_W-1:0] c11;
    logic [DATA_W-1:0] c12;
    logic [DATA_W-1:0] c21;
    logic [DATA_W-1:0] c22;
    logic              ram_req_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [DATA_W-1:0] ram_data_o;
    logic              ram_we_o;
    logic              busy_o;
    logic              is_done_o;
    logic              err_o;

    modport master (
        output start_i, result_baseaddr, result_valid_i, c11, c12, c21, c22,
        input  ram_req_o, ram_addr_o, ram_data_o, ram_we_o, busy_o, is_done_o, err_o
    );

    modport slave (
        input  start_i, result_baseaddr, result_valid_i, c11, c12, c21, c22,
        output ram_req_o, ram_addr_o, ram_data_o, ram_we_o, busy_o, is_done_o, err_o
    );

endinterface

// File: rtl/sa_result_writer.sv
// rtl/sa_result_writer.sv - writes each 2x2 SA output tile into the shared RAM as 4 bytes
module sa_result_writer
    import sa_pkg::*;
#(
    parameter int NUM_TILES = 1
)
(
    input  logic              clk,
    input  logic              rst,
    sa_result_writer_if.slave bus
);

    localparam logic [3:0] LAST_TILE = 4'(NUM_TILES - 1);

    wr_state_t         r_state;
    wr_state_t         w_next;
    logic [ADDR_W-1:0] r_base;
    logic [1:0]        r_idx;
    logic [3:0]        r_tile_cnt;
    logic [DATA_W-1:0] r_tile [TILE_ELEMS];
    logic              r_err;
    logic              w_last_elem;
    logic              w_more_tiles;
    logic              w_writing;

    assign w_last_elem  = (r_idx == 2'd3);
    assign w_more_tiles = (r_tile_cnt < LAST_TILE);
    assign w_writing    = (r_state == S_WRITE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (bus.start_i)        w_next = S_WAIT;
            S_WAIT:         if (bus.result_valid_i) w_next = S_WRITE;
            S_WRITE:        if (w_last_elem)        w_next = w_more_tiles ? S_WAIT : S_DONE;
            default:                                w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_base     <= '0;
            r_idx      <= '0;
            r_tile_cnt <= '0;
            r_err      <= 1'b0;
            for (int i = 0; i < TILE_ELEMS; i++) begin
                r_tile[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start_i) begin
                        r_base     <= bus.result_baseaddr;
                        r_tile_cnt <= '0;
                        r_err      <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (bus.result_valid_i) begin
                        r_tile[0] <= bus.c11;
                        r_tile[1] <= bus.c12;
                        r_tile[2] <= bus.c21;
                        r_tile[3] <= bus.c22;
                        r_idx     <= '0;
                    end
                end
                S_WRITE: begin
                    r_idx <= r_idx + 2'd1;
                    // A tile arriving mid-write is dropped; only the flag records it.
                    if (bus.result_valid_i) begin
                        r_err <= 1'b1;
                    end
                    if (w_last_elem && w_more_tiles) begin
                        r_tile_cnt <= r_tile_cnt + 4'd1;
                        r_base     <= r_base + ADDR_W'(TILE_ELEMS);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ram_req_o  = w_writing;
    assign bus.ram_we_o   = w_writing;
    assign bus.ram_addr_o = w_writing ? (r_base + ADDR_W'(r_idx)) : '0;
    assign bus.ram_data_o = w_writing ? r_tile[r_idx] : '0;
    assign bus.busy_o     = (r_state == S_WAIT) || w_writing;
    assign bus.is_done_o  = (r_state == S_DONE);
    assign bus.err_o      = r_err;

endmodule

// File: tb/tb_sa_result_writer.sv
// tb/tb_sa_result_writer.sv - scoreboard bench for sa_result_writer (1-tile and 2-tile instances)
module tb_sa_result_writer;
    import sa_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sa_result_writer_if ifa ();
    sa_result_writer_if ifb ();

    logic              sel = 1'b0;
    logic              s_start = 1'b0;
    logic              s_valid = 1'b0;
    logic [ADDR_W-1:0] s_base = '0;
    logic [DATA_W-1:0] s_c11 = '0, s_c12 = '0, s_c21 = '0, s_c22 = '0;

    assign ifa.start_i         = s_start & ~sel;
    assign ifa.result_valid_i  = s_valid & ~sel;
    assign ifa.result_baseaddr = s_base;
    assign ifa.c11 = s_c11;
    assign ifa.c12 = s_c12;
    assign ifa.c21 = s_c21;
    assign ifa.c22 = s_c22;
    assign ifb.start_i         = s_start & sel;
    assign ifb.result_valid_i  = s_valid & sel;
    assign ifb.result_baseaddr = s_base;
    assign ifb.c11 = s_c11;
    assign ifb.c12 = s_c12;
    assign ifb.c21 = s_c21;
    assign ifb.c22 = s_c22;

    sa_result_writer #(.NUM_TILES(1)) dut_a (.clk(clk), .rst(rst_n), .bus(ifa));
    sa_result_writer #(.NUM_TILES(2)) dut_b (.clk(clk), .rst(rst_n), .bus(ifb));

    int checks = 0;
    int failures = 0;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mon_write(input string who, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] data);
        logic [ADDR_W+DATA_W-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_unexpected_write: got addr=%0d data=0x%0h expected no write at %0t",
                     who, addr, data, $time);
        end else begin
            e = exp_q.pop_front();
            check({who, "_write"}, 32'({addr, data}), 32'(e));
        end
    endtask

    always @(negedge clk) begin
        if (ifa.ram_we_o) mon_write("a", ifa.ram_addr_o, ifa.ram_data_o);
        else check("a_idle_bus", 32'({ifa.ram_req_o, ifa.ram_addr_o, ifa.ram_data_o}), 32'd0);
        if (ifb.ram_we_o) mon_write("b", ifb.ram_addr_o, ifb.ram_data_o);
        else check("b_idle_bus", 32'({ifb.ram_req_o, ifb.ram_addr_o, ifb.ram_data_o}), 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [ADDR_W-1:0] base);
        s_start = 1'b1;
        s_base  = base;
        tick();
        s_start = 1'b0;
    endtask

    task automatic pulse_tile(input logic [DATA_W-1:0] a, b, c, d);
        s_c11 = a; s_c12 = b; s_c21 = c; s_c22 = d;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic push_tile(input logic [ADDR_W-1:0] base, input logic [DATA_W-1:0] a, b, c, d,
                             input int n);
        logic [DATA_W-1:0] v [4];
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int i = 0; i < n; i++) exp_q.push_back({base + ADDR_W'(i), v[i]});
    endtask

    function automatic logic [31:0] outs_a();
        return 32'({ifa.ram_req_o, ifa.ram_we_o, ifa.ram_addr_o, ifa.ram_data_o,
                    ifa.busy_o, ifa.is_done_o, ifa.err_o});
    endfunction

    function automatic logic [31:0] outs_b();
        return 32'({ifb.ram_req_o, ifb.ram_we_o, ifb.ram_addr_o, ifb.ram_data_o,
                    ifb.busy_o, ifb.is_done_o, ifb.err_o});
    endfunction

    initial begin
        tick();
        tick();
        check("reset_outs_a", outs_a(), 32'd0);
        check("reset_outs_b", outs_b(), 32'd0);
        rst_n = 1'b1;
        tick();

        // single tile at base 8
        start_job(6'd8);
        check("t1_busy_wait", {31'd0, ifa.busy_o}, 32'd1);
        push_tile(6'd8, 8'd11, 8'd12, 8'd21, 8'd22, 4);
        pulse_tile(8'd11, 8'd12, 8'd21, 8'd22);
        check("t1_req_first", {31'd0, ifa.ram_req_o}, 32'd1);
        repeat (4) tick();
        check("t1_done", {30'd0, ifa.busy_o, ifa.is_done_o}, 32'd1);
        check("t1_err", {31'd0, ifa.err_o}, 32'd0);
        check("t1_pending", 32'(exp_q.size()), 32'd0);

        // address wrap at base 62
        start_job(6'd62);
        check("t2_done_drop", {31'd0, ifa.is_done_o}, 32'd0);
        push_tile(6'd62, 8'd1, 8'd2, 8'd3, 8'd4, 4);
        pulse_tile(8'd1, 8'd2, 8'd3, 8'd4);
        repeat (5) tick();
        check("t2_pending", 32'(exp_q.size()), 32'd0);
        check("t2_done", {31'd0, ifa.is_done_o}, 32'd1);

        // two tiles on the NUM_TILES=2 instance
        sel = 1'b1;
        start_job(6'd0);
        push_tile(6'd0, 8'd1, 8'd2, 8'd3, 8'd4, 4);
        pulse_tile(8'd1, 8'd2, 8'd3, 8'd4);
        repeat (4) tick();
        check("t3_between_busy_done", {30'd0, ifb.busy_o, ifb.is_done_o}, 32'd2);
        repeat (2) tick();
        check("t3_gap_busy_done", {30'd0, ifb.busy_o, ifb.is_done_o}, 32'd2);
        push_tile(6'd4, 8'd5, 8'd6, 8'd7, 8'd8, 4);
        pulse_tile(8'd5, 8'd6, 8'd7, 8'd8);
        check("t3_second_busy", {30'd0, ifb.busy_o, ifb.is_done_o}, 32'd2);
        repeat (4) tick();
        check("t3_done", {30'd0, ifb.busy_o, ifb.is_done_o}, 32'd1);
        check("t3_pending", 32'(exp_q.size()), 32'd0);
        sel = 1'b0;

        // overrun during the third write cycle
        start_job(6'd16);
        push_tile(6'd16, 8'd9, 8'd10, 8'd11, 8'd12, 4);
        pulse_tile(8'd9, 8'd10, 8'd11, 8'd12);
        tick();
        tick();
        s_c11 = 8'hAA; s_c12 = 8'hBB; s_c21 = 8'hCC; s_c22 = 8'hDD;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        check("t4_err_set", {31'd0, ifa.err_o}, 32'd1);
        tick();
        check("t4_done_err", {30'd0, ifa.is_done_o, ifa.err_o}, 32'd3);
        check("t4_pending", 32'(exp_q.size()), 32'd0);

        // restart clears err, then reset during idx=1
        start_job(6'd32);
        check("t5_err_cleared", {31'd0, ifa.err_o}, 32'd0);
        push_tile(6'd32, 8'h21, 8'h22, 8'h23, 8'h24, 1);
        pulse_tile(8'h21, 8'h22, 8'h23, 8'h24);
        tick();
        rst_n = 1'b0;
        #1;
        check("t5_reset_outs", outs_a(), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("t5_pending", 32'(exp_q.size()), 32'd0);

        // ignored inputs: valid in IDLE, start in WAIT
        pulse_tile(8'h41, 8'h42, 8'h43, 8'h44);
        tick();
        check("t6_idle_valid", {30'd0, ifa.busy_o, ifa.err_o}, 32'd0);
        start_job(6'd40);
        start_job(6'd50);
        push_tile(6'd40, 8'h31, 8'h32, 8'h33, 8'h34, 4);
        pulse_tile(8'h31, 8'h32, 8'h33, 8'h34);
        repeat (4) tick();
        check("t6_done", {30'd0, ifa.is_done_o, ifa.err_o}, 32'd2);
        check("t6_pending", 32'(exp_q.size()), 32'd0);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
